// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 SDF FFT stage: sequencer state encoding,
// twiddle index width and default stage geometry.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int TW_IDX_W  = 5;
  localparam int DEF_DELAY = 2;
  localparam int DEF_FRAME = 8;

endpackage

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-delay-feedback FFT stage: counts samples,
// steers butterfly/delay line/twiddle index and drains the delay line at end of stream.
module fft_sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int DELAY = DEF_DELAY,
  parameter int FRAME = DEF_FRAME
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                out_ready,
  output logic                out_valid,
  output logic                out_last,
  output logic                bf_mode,
  output logic                dl_en,
  output logic [TW_IDX_W-1:0] mul_cnt,
  output logic                frame_done,
  output logic                busy,
  output state_t              dbg_state
);

  localparam int CW = $clog2(FRAME);
  localparam int PB = $clog2(DELAY);
  localparam int FW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] FILL_LAST = CW'(DELAY - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(FRAME - 1);
  localparam logic [FW-1:0] FL_MAX    = FW'(DELAY - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          frame_done_q, frame_done_d;
  logic          in_fire, out_fire, ph;

  // Handshake: a sample moves on a side only in a cycle where both valid and
  // ready are high on that side; in RUN the input accept and output beat coincide.
  assign ph = in_cnt_q[PB];

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    bf_mode   = 1'b0;
    dl_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        dl_en    = in_valid;
        if (in_valid) state_d = (DELAY == 1) ? ST_RUN : ST_FILL;
      end
      ST_FILL: begin
        in_ready = 1'b1;
        dl_en    = in_valid;
        if (in_valid && in_cnt_q == FILL_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        in_ready  = out_ready;
        out_valid = in_valid;
        bf_mode   = ph;
        dl_en     = in_valid & out_ready;
        // A gap exactly on a frame boundary ends the stream; gaps mid-frame just stall.
        if (!in_valid && out_ready && in_cnt_q == '0) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        out_valid = 1'b1;
        dl_en     = out_ready;
        if (out_ready && flush_cnt_q == FL_MAX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;

    in_cnt_d     = in_fire ? in_cnt_q + CW'(1) : in_cnt_q;
    out_cnt_d    = out_fire ? out_cnt_q + CW'(1) : out_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (state_q == ST_FLUSH && out_ready)
      flush_cnt_d = (flush_cnt_q == FL_MAX) ? '0 : flush_cnt_q + FW'(1);
    frame_done_d = out_fire && (out_cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_last   = out_valid & (out_cnt_q == CNT_MAX);
  assign mul_cnt    = TW_IDX_W'(out_cnt_q);
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Directed bench for fft_sdf_stage_ctrl: a sample-count model checked every cycle,
// plus literal expectations for twiddle order, butterfly phases and frame pulses.
module tb_fft_sdf_stage_ctrl;
  import fft_pkg::*;

  localparam int DELAY = 2;
  localparam int FRAME = 8;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_ready, out_valid, out_last;
  logic        bf_mode, dl_en, frame_done, busy;
  logic [4:0]  mul_cnt;
  state_t      dbg_state;

  fft_sdf_stage_ctrl #(.DELAY(DELAY), .FRAME(FRAME)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
    .bf_mode(bf_mode), .dl_en(dl_en), .mul_cnt(mul_cnt),
    .frame_done(frame_done), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the stage holds (accepted - emitted) samples. Fewer than DELAY held
  // means filling; DELAY held means streaming; a draining flag empties it.
  int acc, emit;
  bit drain, fd_exp;

  typedef struct packed {
    logic       ir, ov, bf, dl, last, bsy;
    logic [4:0] mul;
    logic [1:0] st;
  } exp_t;

  function automatic exp_t model_out(input logic iv, input logic ordy);
    exp_t e;
    int pending;
    pending = acc - emit;
    e = '0;
    if (drain) begin
      e.ov = 1'b1; e.dl = ordy; e.st = 2'(ST_FLUSH);
    end else if (pending < DELAY) begin
      e.ir = 1'b1; e.dl = iv;
      e.st = (pending == 0) ? 2'(ST_IDLE) : 2'(ST_FILL);
    end else begin
      e.ir = ordy; e.ov = iv; e.dl = iv & ordy;
      e.bf = ((acc % (2 * DELAY)) >= DELAY);
      e.st = 2'(ST_RUN);
    end
    e.mul  = 5'(emit % FRAME);
    e.last = e.ov && (emit % FRAME == FRAME - 1);
    e.bsy  = (pending != 0);
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc = 0; emit = 0; drain = 0; fd_exp = 0;
    end else begin
      exp_t e;
      bit in_f, out_f;
      e = model_out(in_valid, out_ready);
      in_f  = in_valid & e.ir;
      out_f = e.ov & out_ready;
      fd_exp = out_f && e.last;
      if (!drain && (acc - emit) >= DELAY && !in_valid && out_ready && (acc % FRAME) == 0)
        drain = 1;
      else if (drain && out_f && (acc - emit) == 1)
        drain = 0;
      acc  += int'(in_f);
      emit += int'(out_f);
    end
  end

  // scoreboard and observation logs
  logic [4:0] exp_q[$];
  logic       bf_log[$];
  int n_in, n_out, n_last, n_fd, n_flush, first_out_at;

  task automatic clear_logs();
    bf_log.delete();
    n_in = 0; n_out = 0; n_last = 0; n_fd = 0; n_flush = 0; first_out_at = -1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_mul_cnt", mul_cnt, 0);
    end else begin
      exp_t e;
      e = model_out(in_valid, out_ready);
      chk("in_ready", in_ready, e.ir);
      chk("out_valid", out_valid, e.ov);
      chk("bf_mode", bf_mode, e.bf);
      chk("dl_en", dl_en, e.dl);
      chk("out_last", out_last, e.last);
      chk("mul_cnt", mul_cnt, e.mul);
      chk("busy", busy, e.bsy);
      chk("state", dbg_state, e.st);
      chk("frame_done", frame_done, fd_exp);
      if (in_valid && in_ready) begin
        n_in++;
        bf_log.push_back(bf_mode);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (first_out_at < 0) first_out_at = n_in;
        if (out_last) n_last++;
        if (dbg_state == ST_FLUSH) n_flush++;
        if (exp_q.size() == 0) chk("sb_extra_output", 1, 0);
        else chk("sb_mul_order", mul_cnt, exp_q.pop_front());
      end
      if (frame_done) n_fd++;
    end
  end

  // driver tasks
  task automatic drive(input logic iv, input logic ordy, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = iv; out_ready = ordy;
      @(posedge clk); #1;
    end
  endtask

  task automatic push_frame();
    for (int i = 0; i < FRAME; i++) exp_q.push_back(5'(i));
  endtask

  task automatic chk_sb_empty(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic bf_ref [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-frame
    exp_q.push_back(5'd0);
    drive(1, 1, 3);
    chk("busy_before_reset", busy, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_in_ready", in_ready, 1);
    chk("async_out_valid", out_valid, 0);
    chk("async_out_last", out_last, 0);
    chk("async_bf_mode", bf_mode, 0);
    chk("async_dl_en", dl_en, 0);
    chk("async_mul_cnt", mul_cnt, 0);
    chk("async_frame_done", frame_done, 0);
    chk("async_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("idle_after_reset", dbg_state, ST_IDLE);
    chk_sb_empty("sb_reset");

    // Single frame
    clear_logs(); push_frame();
    drive(1, 1, 8);
    drive(0, 1, 3);
    @(negedge clk);
    chk("sf_frame_done_pulse", frame_done, 1);
    chk("sf_idle", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    drive(0, 1, 2);
    chk("sf_bf_count", bf_log.size(), 8);
    for (int i = 0; i < 8 && i < bf_log.size(); i++) chk("sf_bf_phase", bf_log[i], bf_ref[i]);
    chk("sf_first_out_accept", first_out_at, 3);
    chk("sf_outputs", n_out, 8);
    chk("sf_flush_beats", n_flush, 2);
    chk("sf_last_count", n_last, 1);
    chk("sf_fd_count", n_fd, 1);
    chk_sb_empty("sb_single");

    // Two frames back-to-back
    clear_logs(); push_frame(); push_frame();
    drive(1, 1, 16);
    drive(0, 1, 5);
    chk("b2b_outputs", n_out, 16);
    chk("b2b_flush_beats", n_flush, 2);
    chk("b2b_last_count", n_last, 2);
    chk("b2b_fd_count", n_fd, 2);
    chk_sb_empty("sb_b2b");

    // Backpressure after five accepts
    clear_logs(); push_frame();
    drive(1, 1, 5);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_dl_en", dl_en, 0);
      chk("bp_mul_held", mul_cnt, 3);
      @(posedge clk); #1;
    end
    drive(1, 1, 3);
    drive(0, 1, 5);
    chk("bp_inputs", n_in, 8);
    chk("bp_outputs", n_out, 8);
    chk_sb_empty("sb_backpressure");

    // Mid-frame bubble
    clear_logs(); push_frame();
    drive(1, 1, 4);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("bub_state_run", dbg_state, ST_RUN);
      chk("bub_out_valid", out_valid, 0);
      @(posedge clk); #1;
    end
    drive(1, 1, 4);
    drive(0, 1, 5);
    chk("bub_outputs", n_out, 8);
    chk("bub_flush_beats", n_flush, 2);
    chk_sb_empty("sb_bubble");

    // Flush under stall, then input arriving on the last flush beat
    clear_logs(); push_frame(); push_frame();
    drive(1, 1, 8);
    drive(0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("fs_out_valid_held", out_valid, 1);
      chk("fs_mul_frozen", mul_cnt, 6);
      chk("fs_dl_en", dl_en, 0);
      @(posedge clk); #1;
    end
    drive(0, 1, 1);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("fs_last_in_ready", in_ready, 0);
    chk("fs_last_mul", mul_cnt, 7);
    chk("fs_last_flag", out_last, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fs_idle_takes", in_ready, 1);
    chk("fs_idle_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    drive(1, 1, 7);
    drive(0, 1, 5);
    chk("fs_inputs", n_in, 16);
    chk("fs_outputs", n_out, 16);
    chk("fs_flush_beats", n_flush, 4);
    chk_sb_empty("sb_flush_stall");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
